btb_predictor: RTL and testbench

- Branch target buffer with 2-bit saturating direction counters. Sits directly upstream of the fetch unit and supplies the predicted next PC for the instruction fetched this cycle.
- Lookup is synchronous, matching the cache convention: it is indexed by the next PC and its result is valid for the current PC.
- Trained by the execute stage through a registered update port.

---
 rtl/btb_pkg.sv | 43 ++++
 rtl/btb_table.sv | 42 ++++
 rtl/btb_predictor.sv | 136 +++++++++++++
 tb/tb_btb_predictor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared widths, counter encoding and entry layout
// for the branch target buffer.
package btb_pkg;

  localparam int BTB_ADDR_WIDTH = 26;
  localparam int BTB_INDEX_BITS = 6;
  localparam int BTB_ENTRIES    = 1 << BTB_INDEX_BITS;
  localparam int TAG_BITS       =
    BTB_ADDR_WIDTH - BTB_INDEX_BITS - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } btb_ctr_t;

  typedef struct packed {
    logic                      valid;
    logic [TAG_BITS-1:0]       tag;
    logic [BTB_ADDR_WIDTH-1:0] target;
    btb_ctr_t                  ctr;
  } btb_entry_t;

  // Saturating step of a 2-bit direction counter.
  function automatic btb_ctr_t sat_update(
    input btb_ctr_t ctr,
    input logic     taken
  );
    btb_ctr_t r;
    r = ctr;
    unique case (1'b1)
      taken && (ctr != ST):
        r = btb_ctr_t'(ctr + 2'd1);
      !taken && (ctr != SNT):
        r = btb_ctr_t'(ctr - 2'd1);
      default:
        r = ctr;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btb_table.sv
// btb_table: direct-mapped entry storage with one synchronous
// read port, one write port and an update-side peek.
module btb_table
  import btb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic [BTB_INDEX_BITS-1:0] rd_idx,
  output btb_entry_t                rd_entry,
  input  logic [BTB_INDEX_BITS-1:0] upd_idx,
  output btb_entry_t                upd_entry,
  input  logic                      wr_en,
  input  logic [BTB_INDEX_BITS-1:0] wr_idx,
  input  btb_entry_t                wr_entry
);

  btb_entry_t mem [BTB_ENTRIES];

  // Storage: reset invalidates every entry and wins over a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  // Read port: old contents are captured on a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_entry <= '0;
    end else if (rd_en) begin
      rd_entry <= mem[rd_idx];
    end
  end

  assign upd_entry = mem[upd_idx];

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: 64-entry BTB with 2-bit direction counters.
// Optional statistics counters: define BTB_STATS_EN.
module btb_predictor
  import btb_pkg::*;
#(
  // Entry layout comes from btb_pkg; keep these in step.
  parameter int ADDR_WIDTH = BTB_ADDR_WIDTH,
  parameter int INDEX_BITS = BTB_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_hit,
  output logic                  o_taken,
  output logic [ADDR_WIDTH-1:0] o_pred_pc,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic                  i_upd_taken,
  input  logic [ADDR_WIDTH-1:0] i_upd_target
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]           o_stat_lookups,
  output logic [31:0]           o_stat_hits,
  output logic [31:0]           o_stat_updates
`endif
);

  logic [ADDR_WIDTH-1:0] cap_pc;
  logic                  cap_vld;
  btb_entry_t            rd_entry;
  btb_entry_t            upd_entry;
  logic                  wr_en;
  btb_entry_t            wr_entry;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   cap_tag;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic                  hit;
  logic                  taken;
  logic                  unused_bits;

  assign lk_idx  = i_lookup_pc[INDEX_BITS+1:2];
  assign upd_idx = i_upd_pc[INDEX_BITS+1:2];
  assign cap_tag = cap_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign upd_tag = i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];

  assign unused_bits = ^i_upd_pc[1:0];

  btb_table u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (!i_stall),
    .rd_idx    (lk_idx),
    .rd_entry  (rd_entry),
    .upd_idx   (upd_idx),
    .upd_entry (upd_entry),
    .wr_en     (wr_en),
    .wr_idx    (upd_idx),
    .wr_entry  (wr_entry)
  );

  // Captured PC travels alongside the table read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_pc  <= '0;
      cap_vld <= 1'b0;
    end else if (!i_stall) begin
      cap_pc  <= i_lookup_pc;
      cap_vld <= 1'b1;
    end
  end

  // Prediction decode; only flops feed these outputs.
  always_comb begin
    hit   = rd_entry.valid && (rd_entry.tag == cap_tag);
    taken = hit && rd_entry.ctr[1];
  end

  assign o_hit     = hit;
  assign o_taken   = taken;
  assign o_pred_pc = !cap_vld ? '0
                   : taken    ? rd_entry.target
                   : cap_pc + ADDR_WIDTH'(4);

  // Training: bump on tag hit, allocate on taken miss.
  always_comb begin
    upd_hit  = upd_entry.valid
             && (upd_entry.tag == upd_tag);
    wr_en    = 1'b0;
    wr_entry = upd_entry;
    if (i_upd_valid) begin
      if (upd_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = sat_update(upd_entry.ctr,
                                  i_upd_taken);
        if (i_upd_taken) begin
          wr_entry.target = i_upd_target;
        end
      end else if (i_upd_taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = upd_tag;
        wr_entry.target = i_upd_target;
        wr_entry.ctr    = WT;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic cap_new;

  // Activity counters; hits are tallied once the read data lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_new        <= 1'b0;
      o_stat_lookups <= '0;
      o_stat_hits    <= '0;
      o_stat_updates <= '0;
    end else begin
      cap_new <= !i_stall;
      if (!i_stall) begin
        o_stat_lookups <= o_stat_lookups + 32'd1;
      end
      if (cap_new && hit) begin
        o_stat_hits <= o_stat_hits + 32'd1;
      end
      if (i_upd_valid) begin
        o_stat_updates <= o_stat_updates + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed vectors against a table model
// of the BTB, checked every cycle plus literal spot checks.
module tb_btb_predictor;

  localparam int AW = 26;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_stall;
  logic [AW-1:0] i_lookup_pc;
  logic          o_hit;
  logic          o_taken;
  logic [AW-1:0] o_pred_pc;
  logic          i_upd_valid;
  logic [AW-1:0] i_upd_pc;
  logic          i_upd_taken;
  logic [AW-1:0] i_upd_target;
`ifdef BTB_STATS_EN
  logic [31:0]   o_stat_lookups;
  logic [31:0]   o_stat_hits;
  logic [31:0]   o_stat_updates;
`endif

  always #5 clk = ~clk;

  btb_predictor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_stall      (i_stall),
    .i_lookup_pc  (i_lookup_pc),
    .o_hit        (o_hit),
    .o_taken      (o_taken),
    .o_pred_pc    (o_pred_pc),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_taken  (i_upd_taken),
    .i_upd_target (i_upd_target)
`ifdef BTB_STATS_EN
    ,
    .o_stat_lookups (o_stat_lookups),
    .o_stat_hits    (o_stat_hits),
    .o_stat_updates (o_stat_updates)
`endif
  );

  int checks = 0;
  int errors = 0;

  bit            m_valid [N];
  int unsigned   m_tag   [N];
  logic [AW-1:0] m_tgt   [N];
  int            m_ctr   [N];
  logic          e_hit;
  logic          e_taken;
  logic [AW-1:0] e_pred;
  bit            started = 0;

  function automatic int idx_of(input logic [AW-1:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int unsigned tag_of(
    input logic [AW-1:0] pc);
    return int'(pc >> 8);
  endfunction

  // Model: lookup sees the table before this edge's update.
  always @(posedge clk) begin
    int i;
    int u;
    started = 1;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 0;
      end
      e_hit   = 0;
      e_taken = 0;
      e_pred  = '0;
    end else begin
      if (!i_stall) begin
        i       = idx_of(i_lookup_pc);
        e_hit   = m_valid[i]
                && (m_tag[i] == tag_of(i_lookup_pc));
        e_taken = e_hit && (m_ctr[i] >= 2);
        e_pred  = e_taken ? m_tgt[i] : i_lookup_pc + 4;
      end
      if (i_upd_valid) begin
        u = idx_of(i_upd_pc);
        if (m_valid[u] && m_tag[u] == tag_of(i_upd_pc)) begin
          if (i_upd_taken) begin
            m_ctr[u] = (m_ctr[u] == 3) ? 3 : m_ctr[u] + 1;
            m_tgt[u] = i_upd_target;
          end else begin
            m_ctr[u] = (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
          end
        end else if (i_upd_taken) begin
          m_valid[u] = 1;
          m_tag[u]   = tag_of(i_upd_pc);
          m_tgt[u]   = i_upd_target;
          m_ctr[u]   = 2;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (o_hit !== e_hit || o_taken !== e_taken
          || o_pred_pc !== e_pred) begin
        errors++;
        $display("FAIL model t=%0t got hit=%b taken=%b pred=%h want hit=%b taken=%b pred=%h",
                 $time, o_hit, o_taken, o_pred_pc,
                 e_hit, e_taken, e_pred);
      end
    end
  end

  task automatic chk(input string name, input logic hit,
                     input logic tk, input logic [AW-1:0] pc);
    checks++;
    if (o_hit !== hit || o_taken !== tk
        || o_pred_pc !== pc) begin
      errors++;
      $display("FAIL %s got hit=%b taken=%b pred=%h want hit=%b taken=%b pred=%h",
               name, o_hit, o_taken, o_pred_pc, hit, tk, pc);
    end
  endtask

  task automatic step(input logic [AW-1:0] lpc,
                      input logic st, input logic uv,
                      input logic [AW-1:0] upc,
                      input logic ut,
                      input logic [AW-1:0] utg);
    i_lookup_pc  = lpc;
    i_stall      = st;
    i_upd_valid  = uv;
    i_upd_pc     = upc;
    i_upd_taken  = ut;
    i_upd_target = utg;
    @(negedge clk);
  endtask

  task automatic look(input logic [AW-1:0] lpc);
    step(lpc, 0, 0, '0, 0, '0);
  endtask

  task automatic upd(input logic [AW-1:0] upc,
                     input logic ut,
                     input logic [AW-1:0] utg);
    step(26'h40, 0, 1, upc, ut, utg);
  endtask

  initial begin
    rst_n = 0;
    step(26'h0, 0, 1, 26'h140, 1, 26'h500);
    step(26'h0, 0, 1, 26'h140, 1, 26'h500);
    chk("reset", 0, 0, 26'h0);
    rst_n = 1;

    look(26'h40);
    chk("cold_miss", 0, 0, 26'h44);
    look(26'h140);
    chk("no_alloc_in_reset", 0, 0, 26'h144);

    step(26'h0, 0, 1, 26'h100, 1, 26'h200);
    chk("rbw_idx0", 0, 0, 26'h4);
    look(26'h100);
    chk("alloc", 1, 1, 26'h200);

    upd(26'h100, 0, '0);
    upd(26'h100, 0, '0);
    look(26'h100);
    chk("ctr_00", 1, 0, 26'h104);
    upd(26'h100, 0, '0);
    upd(26'h100, 1, 26'h200);
    look(26'h100);
    chk("sat_low", 1, 0, 26'h104);

    upd(26'h100, 1, 26'h200);
    upd(26'h100, 1, 26'h200);
    upd(26'h100, 1, 26'h200);
    upd(26'h100, 0, '0);
    look(26'h100);
    chk("sat_high", 1, 1, 26'h200);
    upd(26'h100, 0, '0);
    upd(26'h100, 1, 26'h280);
    look(26'h100);
    chk("retarget", 1, 1, 26'h280);

    upd(26'h200, 1, 26'h300);
    look(26'h100);
    chk("evicted", 0, 0, 26'h104);
    look(26'h200);
    chk("alias_hit", 1, 1, 26'h300);

    step(26'h80, 0, 1, 26'h80, 1, 26'h900);
    chk("same_cycle", 0, 0, 26'h84);
    look(26'h80);
    chk("next_cycle", 1, 1, 26'h900);

    look(26'h200);
    step(26'h80, 1, 1, 26'h200, 0, '0);
    chk("stall_1", 1, 1, 26'h300);
    step(26'h100, 1, 0, '0, 0, '0);
    chk("stall_2", 1, 1, 26'h300);
    step(26'h40, 1, 0, '0, 0, '0);
    chk("stall_3", 1, 1, 26'h300);
    look(26'h200);
    chk("post_stall", 1, 0, 26'h204);

    look(26'h202);
    chk("low_bits", 1, 0, 26'h206);
    look(26'h3FFFFFC);
    chk("wrap", 0, 0, 26'h0);

    rst_n = 0;
    step(26'h40, 0, 1, 26'h40, 1, 26'h777);
    chk("reset_2", 0, 0, 26'h0);
    rst_n = 1;
    look(26'h200);
    chk("cleared", 0, 0, 26'h204);
    look(26'h40);
    chk("dropped_upd", 0, 0, 26'h44);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
